// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 scan-code tracker.
package ps2_pkg;

  localparam logic [7:0] PREFIX_EXT  = 8'hE0;
  localparam logic [7:0] PREFIX_BRK  = 8'hF0;
  localparam logic [7:0] ERR_ZERO    = 8'h00;
  localparam logic [7:0] ERR_OVERRUN = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_e;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } held_entry_t;

endpackage

// File: rtl/ps2_held_key_table.sv
// Table of currently held keys: {ext, code} lookup, lowest-free allocation,
// clear on release and occupancy count.
module ps2_held_key_table
  import ps2_pkg::*;
#(
  parameter int unsigned KEY_SLOTS = 4,
  localparam int unsigned CW = $clog2(KEY_SLOTS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_ext,
  input  logic [7:0]    key_code,
  input  logic          make,
  input  logic          brk,
  output logic          hit,
  output logic          full,
  output logic [CW-1:0] count
);

  held_entry_t          slots [KEY_SLOTS];
  logic [KEY_SLOTS-1:0] match;
  logic [KEY_SLOTS-1:0] free;
  logic [KEY_SLOTS-1:0] alloc;

  always_comb begin
    match = '0;
    free  = '0;
    count = '0;
    for (int unsigned i = 0; i < KEY_SLOTS; i++) begin
      match[i] = slots[i].valid && (slots[i].ext == key_ext) && (slots[i].code == key_code);
      free[i]  = !slots[i].valid;
      count    = count + CW'(slots[i].valid);
    end
    hit   = |match;
    full  = ~|free;
    // Isolate the lowest set bit of the free mask.
    alloc = free & (~free + KEY_SLOTS'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < KEY_SLOTS; i++) slots[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < KEY_SLOTS; i++) begin
        if (make && !hit && alloc[i]) slots[i] <= '{valid: 1'b1, ext: key_ext, code: key_code};
        if (brk && match[i]) slots[i].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_code_tracker.sv
// PS/2 set-2 byte parser: folds E0/F0 prefixes into make/release events,
// tracks held keys, flags typematic repeats and keeps a hex make-code history.
module ps2_scan_code_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned KEY_SLOTS      = 4,
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic                           CodeValid,
  input  logic [7:0]                     KeyboardCode,
  output logic                           EventValid,
  output logic [7:0]                     EventCode,
  output logic                           EventExt,
  output logic                           EventRelease,
  output logic                           EventRepeat,
  output logic [$clog2(KEY_SLOTS+1)-1:0] HeldCount,
  output logic                           AnyHeld,
  output logic                           Overflow,
  output logic                           ProtoError,
  output logic [4*DIGITS-1:0]            HexDigits
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  parse_state_e        state_q, state_d;
  logic [TW-1:0]       timer_q;
  logic                timeout;
  logic                emit;
  logic                err_d;
  logic                ev_ext;
  logic                ev_rel;
  logic                hit;
  logic                full;
  logic                new_make;
  logic [4*DIGITS-1:0] hex_shift;

  ps2_held_key_table #(
    .KEY_SLOTS(KEY_SLOTS)
  ) u_table (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .key_ext (ev_ext),
    .key_code(KeyboardCode),
    .make    (emit && !ev_rel),
    .brk     (emit && ev_rel),
    .hit     (hit),
    .full    (full),
    .count   (HeldCount)
  );

  assign AnyHeld = |HeldCount;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    emit    = 1'b0;
    ev_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    ev_rel  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    timeout = (state_q != ST_IDLE) && (timer_q == TW'(TIMEOUT_CYCLES - 1)) && !CodeValid;
    if (CodeValid) begin
      if (KeyboardCode == ERR_ZERO || KeyboardCode == ERR_OVERRUN) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else if (KeyboardCode == PREFIX_EXT) begin
        unique case (state_q)
          ST_IDLE, ST_EXT: state_d = ST_EXT;
          ST_BRK:          begin state_d = ST_EXT;  err_d = 1'b1; end
          ST_EXT_BRK:      begin state_d = ST_IDLE; err_d = 1'b1; end
          default:         state_d = ST_IDLE;
        endcase
      end else if (KeyboardCode == PREFIX_BRK) begin
        unique case (state_q)
          ST_IDLE, ST_BRK: state_d = ST_BRK;
          ST_EXT:          state_d = ST_EXT_BRK;
          ST_EXT_BRK:      begin state_d = ST_IDLE; err_d = 1'b1; end
          default:         state_d = ST_IDLE;
        endcase
      end else begin
        emit    = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
    new_make  = emit && !ev_rel && !hit;
    hex_shift = HexDigits << 8;
    hex_shift[7:0] = KeyboardCode;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (CodeValid || state_q == ST_IDLE || timeout) timer_q <= '0;
      else                                          timer_q <= timer_q + TW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      EventValid   <= 1'b0;
      EventCode    <= '0;
      EventExt     <= 1'b0;
      EventRelease <= 1'b0;
      EventRepeat  <= 1'b0;
      ProtoError   <= 1'b0;
      Overflow     <= 1'b0;
      HexDigits    <= '0;
    end else begin
      EventValid <= emit;
      ProtoError <= err_d;
      if (emit) begin
        EventCode    <= KeyboardCode;
        EventExt     <= ev_ext;
        EventRelease <= ev_rel;
        EventRepeat  <= !ev_rel && hit;
      end
      if (new_make) HexDigits <= hex_shift;
      if (new_make && full)    Overflow <= 1'b1;
      else if (HeldCount == 0) Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_code_tracker.sv
// Scoreboard bench for ps2_scan_code_tracker with directed byte sequences.
module tb_ps2_scan_code_tracker;

  localparam int unsigned KS = 4;
  localparam int unsigned DG = 4;
  localparam int unsigned TO = 50000;
  localparam int unsigned CW = $clog2(KS + 1);

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          CodeValid = 1'b0;
  logic [7:0]    KeyboardCode = '0;
  logic          EventValid;
  logic [7:0]    EventCode;
  logic          EventExt;
  logic          EventRelease;
  logic          EventRepeat;
  logic [CW-1:0] HeldCount;
  logic          AnyHeld;
  logic          Overflow;
  logic          ProtoError;
  logic [4*DG-1:0] HexDigits;

  ps2_scan_code_tracker #(
    .KEY_SLOTS(KS),
    .DIGITS(DG),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .CodeValid(CodeValid), .KeyboardCode(KeyboardCode),
    .EventValid(EventValid), .EventCode(EventCode), .EventExt(EventExt),
    .EventRelease(EventRelease), .EventRepeat(EventRepeat), .HeldCount(HeldCount),
    .AnyHeld(AnyHeld), .Overflow(Overflow), .ProtoError(ProtoError), .HexDigits(HexDigits)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          is_err;
    logic [7:0]  code;
    bit          ext;
    bit          rel;
    bit          rep;
    int unsigned held;
    logic [15:0] hex;
    bit          ov;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_ev(input logic [7:0] code, input bit ext, input bit rel, input bit rep,
                        input int unsigned held, input logic [15:0] hex, input bit ov);
    sb.push_back('{is_err: 1'b0, code: code, ext: ext, rel: rel, rep: rep, held: held, hex: hex, ov: ov});
  endtask

  task automatic exp_err();
    sb.push_back('{is_err: 1'b1, code: 8'h00, ext: 1'b0, rel: 1'b0, rep: 1'b0, held: 0, hex: 16'h0, ov: 1'b0});
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge Clock);
    CodeValid    = 1'b1;
    KeyboardCode = b;
    @(negedge Clock);
    CodeValid    = 1'b0;
  endtask

  task automatic drain(input int unsigned max, output int unsigned n);
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge Clock);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge Clock);
  endtask

  always @(negedge Clock) begin
    if (Reset_n && (EventValid || ProtoError)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual ev=%0b err=%0b code=%0h required none at %0t",
                 EventValid, ProtoError, EventCode, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_err) begin
          chk("proto_err", 32'({EventValid, ProtoError}), 32'b01);
        end else begin
          chk("ev_valid_only", 32'({EventValid, ProtoError}), 32'b10);
          chk("ev_code", 32'(EventCode), 32'(e.code));
          chk("ev_flags", 32'({EventExt, EventRelease, EventRepeat}), 32'({e.ext, e.rel, e.rep}));
          chk("held_count", 32'(HeldCount), 32'(e.held));
          chk("any_held", 32'(AnyHeld), 32'(e.held != 0));
          chk("hex_digits", 32'(HexDigits), 32'(e.hex));
          chk("overflow", 32'(Overflow), 32'(e.ov));
        end
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_ev"}, 32'({EventValid, EventCode, EventExt, EventRelease, EventRepeat, ProtoError}), 32'd0);
    chk({name, "_state"}, 32'({HeldCount, AnyHeld, Overflow, HexDigits}), 32'd0);
  endtask

  initial begin
    int unsigned n;
    repeat (3) @(negedge Clock);
    chk_all_zero("reset");
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);

    // basic make / break
    exp_ev(8'h1C, 0, 0, 0, 1, 16'h001C, 0);
    send(8'h1C);
    exp_ev(8'h1C, 0, 1, 0, 0, 16'h001C, 0);
    send(8'hF0); send(8'h1C);
    drain(20, n);

    // extended make / break
    exp_ev(8'h75, 1, 0, 0, 1, 16'h1C75, 0);
    send(8'hE0); send(8'h75);
    exp_ev(8'h75, 1, 1, 0, 0, 16'h1C75, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain(20, n);

    // typematic repeat
    exp_ev(8'h1C, 0, 0, 0, 1, 16'h751C, 0);
    exp_ev(8'h1C, 0, 0, 1, 1, 16'h751C, 0);
    exp_ev(8'h1C, 0, 0, 1, 1, 16'h751C, 0);
    send(8'h1C); send(8'h1C); send(8'h1C);
    exp_ev(8'h1C, 0, 1, 0, 0, 16'h751C, 0);
    send(8'hF0); send(8'h1C);
    drain(20, n);

    // table fill and overflow
    exp_ev(8'h15, 0, 0, 0, 1, 16'h1C15, 0); send(8'h15);
    exp_ev(8'h1D, 0, 0, 0, 2, 16'h151D, 0); send(8'h1D);
    exp_ev(8'h24, 0, 0, 0, 3, 16'h1D24, 0); send(8'h24);
    exp_ev(8'h2D, 0, 0, 0, 4, 16'h242D, 0); send(8'h2D);
    exp_ev(8'h2C, 0, 0, 0, 4, 16'h2D2C, 1); send(8'h2C);
    exp_ev(8'h15, 0, 1, 0, 3, 16'h2D2C, 1); send(8'hF0); send(8'h15);
    exp_ev(8'h1D, 0, 1, 0, 2, 16'h2D2C, 1); send(8'hF0); send(8'h1D);
    exp_ev(8'h24, 0, 1, 0, 1, 16'h2D2C, 1); send(8'hF0); send(8'h24);
    exp_ev(8'h2D, 0, 1, 0, 0, 16'h2D2C, 1); send(8'hF0); send(8'h2D);
    drain(20, n);
    chk("overflow_cleared", 32'(Overflow), 32'd0);
    exp_ev(8'h2C, 0, 1, 0, 0, 16'h2D2C, 0); send(8'hF0); send(8'h2C);
    drain(20, n);

    // protocol errors
    exp_err();
    send(8'hF0); send(8'hE0);
    exp_ev(8'h75, 1, 0, 0, 1, 16'h2C75, 0);
    send(8'h75);
    exp_err();
    send(8'hE0); send(8'hF0); send(8'hE0);
    exp_ev(8'h75, 1, 1, 0, 0, 16'h2C75, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    exp_err();
    send(8'hE0); send(8'h00);
    exp_ev(8'h1C, 0, 0, 0, 1, 16'h751C, 0);
    send(8'h1C);
    exp_ev(8'h1C, 0, 1, 0, 0, 16'h751C, 0);
    send(8'hF0); send(8'h1C);
    drain(20, n);

    // prefix timeout
    exp_err();
    send(8'hE0);
    drain(TO + 100, n);
    chk("timeout_latency_ok", 32'(n >= TO - 10), 32'd1);
    exp_ev(8'h1C, 0, 0, 0, 1, 16'h1C1C, 0);
    send(8'h1C);
    drain(20, n);

    // reset mid-sequence
    send(8'hF0);
    Reset_n = 1'b0;
    @(negedge Clock);
    chk_all_zero("midreset1");
    @(negedge Clock);
    chk_all_zero("midreset2");
    Reset_n = 1'b1;
    @(negedge Clock);
    exp_ev(8'h1C, 0, 0, 0, 1, 16'h001C, 0);
    send(8'h1C);
    exp_err();
    send(8'hFF);
    drain(20, n);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scan_code_tracker.md
Name: ps2_scan_code_tracker

Overview:
- Successor to the single-byte keyboard code decoder.
- Consumes PS/2 set-2 scan-code bytes, one per CodeValid strobe, and parses E0 (extended) and F0 (break) prefixes into single make/release events.
- Tracks up to KEY_SLOTS simultaneously held keys, flags typematic repeats, and keeps a DIGITS-nibble hex history of make codes for the seven-segment path.
- Sits between the PS/2 byte receiver and the piano note/display logic.

Parameters:
- KEY_SLOTS, 4, number of held-key table entries (1..8).
- DIGITS, 2, hex nibbles in the display history. Even, 2..8; each make code shifts in 2 nibbles.
- TIMEOUT_CYCLES, 50000, Clock cycles allowed between a prefix byte and the following byte (1 ms at 50 MHz).

Ports:
- Clock  in  1  system clock, all logic on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- CodeValid  in  1  one-cycle strobe: KeyboardCode holds a new byte.
- KeyboardCode  in  8  received scan-code byte.
- EventValid  out  1  one-cycle pulse: Event* fields are valid.
- EventCode  out  8  key code of the event (prefixes stripped).
- EventExt  out  1  event carried the E0 prefix.
- EventRelease  out  1  1 = break, 0 = make.
- EventRepeat  out  1  make of a key already held (typematic).
- HeldCount  out  $clog2(KEY_SLOTS+1)  number of occupied table slots.
- AnyHeld  out  1  HeldCount != 0.
- Overflow  out  1  sticky: a new make was dropped because the table was full.
- ProtoError  out  1  one-cycle pulse on protocol error or prefix timeout.
- HexDigits  out  4*DIGITS  make-code history; [7:0] is the newest code.

Behaviour:
- Reset (async, Reset_n=0): FSM to IDLE, timer 0, table empty. All outputs 0, including HexDigits and Overflow.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). The FSM changes only on CodeValid, except for timeout.
- IDLE: E0->EXT, F0->BRK.
- EXT: F0->EXT_BRK, E0->EXT (duplicate prefix tolerated).
- BRK: F0->BRK. E0->EXT with ProtoError pulse.
- EXT_BRK: E0 or F0 -> IDLE with ProtoError pulse.
- Any other byte in any state is a key byte: emit an event, return to IDLE.
  - EventExt = (state is EXT or EXT_BRK).
  - EventRelease = (state is BRK or EXT_BRK).
- Bytes 00 and FF (receiver error/overrun) in any state: no event, ProtoError pulse, go to IDLE.
- Latency: Event* outputs and ProtoError are registered and assert in the cycle after the CodeValid byte is sampled. Event* fields hold their value until the next event.
- Timeout: timer clears on every CodeValid and counts while state != IDLE. On reaching TIMEOUT_CYCLES-1: state->IDLE, ProtoError pulse, no event. If CodeValid arrives in that same cycle, the byte wins and the timeout is suppressed.
- Held table: each entry is {valid, ext, code[7:0]}; lookup compares {ext, code}.
- Make, key present: EventRepeat=1; table and HexDigits unchanged.
- Make, key absent, free slot: write to the lowest free slot; HexDigits shifts left 8 bits, EventCode enters [7:0].
- Make, key absent, table full: event still emitted with EventRepeat=0. Entry dropped, Overflow set, HexDigits still updated.
- Release, key present: slot cleared.
- Release, key absent: event emitted, table unchanged.
- Overflow clears when HeldCount reaches 0 (the cycle after the last release updates the table).
- HeldCount, AnyHeld and HexDigits update in the same cycle as EventValid.
- Reset mid-sequence (e.g. after E0) discards the prefix. The first post-reset byte is parsed from IDLE.

Decomposition:
- ps2_pkg: prefix constants (E0, F0), error bytes (00, FF), the FSM state enum, and the held-entry struct {valid, ext, code}.
- One sub-module: ps2_held_key_table (lookup, lowest-free allocate, clear, occupancy count, full flag). Parser FSM, timer and hex history stay in the top module.

Test Plan:
- Bytes 1C -> one EventValid, Code=1C, Ext=0, Release=0, Repeat=0; HexDigits=8'h1C; HeldCount=1. Then F0,1C -> Release=1, HeldCount=0, HexDigits still 1C.
- E0,75 then E0,F0,75 -> make Code=75, Ext=1, then release Code=75, Ext=1. Exactly two EventValid pulses total, none on prefix bytes.
- 1C,1C,1C -> three events; the 2nd and 3rd have Repeat=1; HeldCount stays 1; HexDigits=1C.
- Makes 15,1D,24,2D,2C with KEY_SLOTS=4 -> HeldCount=4, Overflow=1 after 2C, HexDigits=16'h2D2C (DIGITS=4). Releasing the four held keys -> Overflow=0.
- E0 then idle 50000 cycles -> ProtoError pulse, no event. Next byte 1C is decoded as non-extended.
- F0 then assert Reset_n=0 for 2 cycles, then byte 1C -> make event, Release=0; all outputs were 0 during reset. Byte FF -> ProtoError, no event.
